// File: rtl/data_unshift_if.sv
// Byte-sequencer bus: command frame in, one byte at a time out over valid/ready.
// Latency: none (signal bundle only).
// Backpressure: i_tx_byte_ready from the SPI transmitter stalls the byte stream.
//
// Ports (signal bundle):
//   i_tx_data        frame word from PS AXI, MSB byte sent first
//   i_tx_start       single-cycle start strobe
//   o_busy           frame in progress
//   o_tx_done        one-cycle pulse after the last byte is accepted
//   o_tx_byte        byte currently offered to the SPI transmitter
//   o_tx_byte_valid  o_tx_byte is valid
//   i_tx_byte_ready  SPI transmitter accepts the byte this cycle
//
// Modports: master is the sequencer itself (it drives the byte stream),
// slave is everything around it (PS register file and SPI transmitter).
interface data_unshift_if #(
    parameter int TOTAL_DATA_BYTE = 7,
    parameter int DATA_WIDTH      = 8
);
    logic [TOTAL_DATA_BYTE*DATA_WIDTH-1:0] i_tx_data;
    logic                                  i_tx_start;
    logic                                  o_busy;
    logic                                  o_tx_done;
    logic [DATA_WIDTH-1:0]                 o_tx_byte;
    logic                                  o_tx_byte_valid;
    logic                                  i_tx_byte_ready;

    modport master (
        input  i_tx_data,
        input  i_tx_start,
        input  i_tx_byte_ready,
        output o_busy,
        output o_tx_done,
        output o_tx_byte,
        output o_tx_byte_valid
    );

    modport slave (
        output i_tx_data,
        output i_tx_start,
        output i_tx_byte_ready,
        input  o_busy,
        input  o_tx_done,
        input  o_tx_byte,
        input  o_tx_byte_valid
    );
endinterface

// File: rtl/data_unshift.sv
// Transmit byte sequencer: captures a frame on start, emits it MSB byte first.
// Latency: first byte valid 1 cycle after start; BYTE_GAP idle cycles between bytes.
// Backpressure: a byte is held stable (valid high) until i_tx_byte_ready is seen.
//
// Ports:
//   i_clk    system clock, rising edge
//   i_reset  synchronous active-high reset; abandons any frame without done
//   bus      data_unshift_if.master: start/frame in, byte valid/ready out,
//            busy and done status
module data_unshift #(
    parameter int TOTAL_DATA_BYTE = 7,
    parameter int DATA_WIDTH      = 8,
    parameter int BYTE_GAP        = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    data_unshift_if.master    bus
);

    localparam int FRAME_W = TOTAL_DATA_BYTE * DATA_WIDTH;

    // Counter widths are fixed: 4 bits covers up to 15 bytes, 8 bits up to 255 gap cycles.
    localparam logic [3:0] LAST_CNT = 4'(TOTAL_DATA_BYTE);
    localparam logic [7:0] GAP_LOAD = (BYTE_GAP > 0) ? 8'(BYTE_GAP - 1) : 8'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   shreg_q, shreg_d;
    logic [3:0]           byte_cnt_q, byte_cnt_d;
    logic [7:0]           gap_cnt_q, gap_cnt_d;
    logic                 xfer;

    // A byte moves only while it is being offered; ready is ignored otherwise.
    assign xfer = (state_q == ST_SEND) && bus.i_tx_byte_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;

        case (state_q)
            ST_IDLE: begin
                // Frame is captured here only; later changes on i_tx_data are
                // invisible to the frame in flight.
                if (bus.i_tx_start) begin
                    shreg_d    = bus.i_tx_data;
                    byte_cnt_d = '0;
                    gap_cnt_d  = '0;
                    state_d    = ST_SEND;
                end
            end

            ST_SEND: begin
                if (xfer) begin
                    // Zero fill: after the last byte the register is empty,
                    // so nothing stale is left behind for the idle period.
                    shreg_d    = shreg_q << DATA_WIDTH;
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    if (byte_cnt_d == LAST_CNT) begin
                        state_d = ST_DONE;
                    end else if (BYTE_GAP > 0) begin
                        gap_cnt_d = GAP_LOAD;
                        state_d   = ST_GAP;
                    end else begin
                        // Zero gap: next byte offered straight away.
                        state_d = ST_SEND;
                    end
                end
            end

            ST_GAP: begin
                // Counter starts at BYTE_GAP-1 so the gap lasts exactly BYTE_GAP cycles.
                if (gap_cnt_q == 8'd0) begin
                    state_d = ST_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end

            ST_DONE: begin
                // Start is ignored here too; a new frame needs a cycle of IDLE.
                byte_cnt_d = '0;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // ------------------------------------------------------------------
    assign bus.o_busy          = (state_q != ST_IDLE);
    assign bus.o_tx_byte_valid = (state_q == ST_SEND);
    assign bus.o_tx_done       = (state_q == ST_DONE);
    // Byte bus is forced to zero while not offered so the line is quiet in gaps.
    assign bus.o_tx_byte       = (state_q == ST_SEND) ? shreg_q[FRAME_W-1 -: DATA_WIDTH]
                                                      : '0;

endmodule

// File: tb/tb_data_unshift.sv
// Bench for data_unshift: default instance (7 bytes, gap 2) and a 3-byte, gap-0 instance.
// Bytes are scored against queues filled when each frame is started.
module tb_data_unshift;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    data_unshift_if ifa ();
    data_unshift_if #(.TOTAL_DATA_BYTE(3), .DATA_WIDTH(8)) ifb ();

    data_unshift u_a (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (ifa.master)
    );

    data_unshift #(.TOTAL_DATA_BYTE(3), .DATA_WIDTH(8), .BYTE_GAP(0)) u_b (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (ifb.master)
    );

    int errors;
    int checks;
    int done_a;
    int done_b;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: score transfers just before the edge, then return #1 after it.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        if (ifa.o_tx_byte_valid && ifa.i_tx_byte_ready) begin
            chk("a_xfer_expected", 64'(qa.size() != 0), 64'd1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("a_byte", 64'(ifa.o_tx_byte), 64'(e));
            end
        end
        if (ifb.o_tx_byte_valid && ifb.i_tx_byte_ready) begin
            chk("b_xfer_expected", 64'(qb.size() != 0), 64'd1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("b_byte", 64'(ifb.o_tx_byte), 64'(e));
            end
        end
        if (ifa.o_tx_done) done_a++;
        if (ifb.o_tx_done) done_b++;
        @(posedge clk);
        #1;
    endtask

    task automatic start_a(input logic [55:0] d);
        ifa.i_tx_data  = d;
        ifa.i_tx_start = 1'b1;
        for (int i = 0; i < 7; i++) qa.push_back(d[55-8*i -: 8]);
        tick();
        ifa.i_tx_start = 1'b0;
    endtask

    task automatic start_b(input logic [23:0] d);
        ifb.i_tx_data  = d;
        ifb.i_tx_start = 1'b1;
        for (int i = 0; i < 3; i++) qb.push_back(d[23-8*i -: 8]);
        tick();
        ifb.i_tx_start = 1'b0;
    endtask

    initial begin
        int c;
        errors = 0;
        checks = 0;
        done_a = 0;
        done_b = 0;
        rst = 1'b1;
        ifa.i_tx_data = '0; ifa.i_tx_start = 1'b0; ifa.i_tx_byte_ready = 1'b0;
        ifb.i_tx_data = '0; ifb.i_tx_start = 1'b0; ifb.i_tx_byte_ready = 1'b0;
        tick();
        tick();

        // ---- reset state ----
        chk("rst_a_busy",  64'(ifa.o_busy), 64'd0);
        chk("rst_a_valid", 64'(ifa.o_tx_byte_valid), 64'd0);
        chk("rst_a_done",  64'(ifa.o_tx_done), 64'd0);
        chk("rst_a_byte",  64'(ifa.o_tx_byte), 64'd0);
        chk("rst_b_busy",  64'(ifb.o_busy), 64'd0);
        chk("rst_b_valid", 64'(ifb.o_tx_byte_valid), 64'd0);
        rst = 1'b0;
        tick();

        // ---- defaults, continuous ready: bytes at cycles 1,4,..,19, done at 20 ----
        ifa.i_tx_byte_ready = 1'b1;
        done_a = 0;
        start_a(56'h01_23_45_67_89_AB_CD);
        for (int k = 1; k <= 21; k++) begin
            chk("t1_valid", 64'(ifa.o_tx_byte_valid), 64'((k <= 19) && (k % 3 == 1)));
            chk("t1_busy",  64'(ifa.o_busy), 64'(k <= 20));
            chk("t1_done",  64'(ifa.o_tx_done), 64'(k == 20));
            tick();
        end
        chk("t1_done_cnt", 64'(done_a), 64'd1);
        chk("t1_q_empty", 64'(qa.size()), 64'd0);

        // ---- backpressure: ready low for 5 cycles on 0x45 ----
        done_a = 0;
        start_a(56'h01_23_45_67_89_AB_CD);
        c = 1;
        while (!(ifa.o_tx_byte_valid && ifa.o_tx_byte == 8'h45) && c < 60) begin
            tick();
            c++;
        end
        chk("bp_reach_45", 64'(c), 64'd7);
        ifa.i_tx_byte_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_byte",  64'(ifa.o_tx_byte), 64'h45);
            chk("bp_hold_valid", 64'(ifa.o_tx_byte_valid), 64'd1);
            tick();
            c++;
        end
        ifa.i_tx_byte_ready = 1'b1;
        chk("bp_still_45", 64'(ifa.o_tx_byte), 64'h45);
        tick(); c++;
        chk("bp_gap1_valid", 64'(ifa.o_tx_byte_valid), 64'd0);
        tick(); c++;
        chk("bp_gap2_valid", 64'(ifa.o_tx_byte_valid), 64'd0);
        tick(); c++;
        chk("bp_next_valid", 64'(ifa.o_tx_byte_valid), 64'd1);
        chk("bp_next_byte",  64'(ifa.o_tx_byte), 64'h67);
        while (!ifa.o_tx_done && c < 100) begin
            tick();
            c++;
        end
        chk("bp_done_cycle", 64'(c), 64'd25);
        tick();
        chk("bp_busy_after", 64'(ifa.o_busy), 64'd0);
        chk("bp_done_cnt", 64'(done_a), 64'd1);
        chk("bp_q_empty", 64'(qa.size()), 64'd0);

        // ---- BYTE_GAP=0, 3 bytes: A1,B2,C3 back to back, done in cycle 4 ----
        ifb.i_tx_byte_ready = 1'b1;
        done_b = 0;
        start_b(24'hA1B2C3);
        for (int k = 1; k <= 5; k++) begin
            chk("g0_valid", 64'(ifb.o_tx_byte_valid), 64'(k <= 3));
            chk("g0_done",  64'(ifb.o_tx_done), 64'(k == 4));
            chk("g0_busy",  64'(ifb.o_busy), 64'(k <= 4));
            tick();
        end
        chk("g0_done_cnt", 64'(done_b), 64'd1);
        chk("g0_q_empty", 64'(qb.size()), 64'd0);

        // ---- start while busy: during byte 2 and during DONE ----
        done_a = 0;
        start_a(56'h01_23_45_67_89_AB_CD);
        c = 1;
        while (!(ifa.o_tx_byte_valid && ifa.o_tx_byte == 8'h45) && c < 60) begin
            tick();
            c++;
        end
        ifa.i_tx_data  = 56'hFF_FF_FF_FF_FF_FF_FF;
        ifa.i_tx_start = 1'b1;
        tick(); c++;
        ifa.i_tx_start = 1'b0;
        while (!ifa.o_tx_done && c < 100) begin
            tick();
            c++;
        end
        chk("sb_done_cycle", 64'(c), 64'd20);
        ifa.i_tx_start = 1'b1;
        tick();
        ifa.i_tx_start = 1'b0;
        chk("sb_busy_after",  64'(ifa.o_busy), 64'd0);
        chk("sb_valid_after", 64'(ifa.o_tx_byte_valid), 64'd0);
        tick();
        chk("sb_busy_later", 64'(ifa.o_busy), 64'd0);
        chk("sb_done_cnt", 64'(done_a), 64'd1);
        chk("sb_q_empty", 64'(qa.size()), 64'd0);

        // ---- reset mid-frame after byte 3 (0x67) transfers ----
        done_a = 0;
        start_a(56'h01_23_45_67_89_AB_CD);
        c = 1;
        while (!(ifa.o_tx_byte_valid && ifa.o_tx_byte == 8'h67) && c < 60) begin
            tick();
            c++;
        end
        chk("rm_reach_67", 64'(c), 64'd10);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rm_busy",  64'(ifa.o_busy), 64'd0);
        chk("rm_valid", 64'(ifa.o_tx_byte_valid), 64'd0);
        chk("rm_done",  64'(ifa.o_tx_done), 64'd0);
        chk("rm_byte",  64'(ifa.o_tx_byte), 64'd0);
        qa.delete();
        for (int i = 0; i < 30; i++) tick();
        chk("rm_no_done", 64'(done_a), 64'd0);
        start_a(56'h11_22_33_44_55_66_77);
        chk("rm_new_valid", 64'(ifa.o_tx_byte_valid), 64'd1);
        chk("rm_new_first", 64'(ifa.o_tx_byte), 64'h11);
        c = 1;
        while (!ifa.o_tx_done && c < 100) begin
            tick();
            c++;
        end
        chk("rm_done_cycle", 64'(c), 64'd20);
        tick();
        chk("rm_done_cnt", 64'(done_a), 64'd1);
        chk("rm_q_empty", 64'(qa.size()), 64'd0);

        // ---- idle noise: no start, ready and data toggling ----
        for (int i = 0; i < 50; i++) begin
            ifa.i_tx_byte_ready = 1'($urandom_range(0, 1));
            ifb.i_tx_byte_ready = 1'($urandom_range(0, 1));
            ifa.i_tx_data = {24'($urandom), $urandom};
            ifb.i_tx_data = 24'($urandom);
            tick();
            chk("idle_a_quiet", 64'({ifa.o_tx_byte_valid, ifa.o_busy, ifa.o_tx_done}), 64'd0);
            chk("idle_b_quiet", 64'({ifb.o_tx_byte_valid, ifb.o_busy, ifb.o_tx_done}), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
